// File: rtl/isqrt_pkg.sv
// Shared state encoding and derived-width helpers for the iterative square-root unit.
package isqrt_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int unsigned rad_w(input int unsigned w);
        return 2 * w + 2;
    endfunction

    function automatic int unsigned root_w(input int unsigned w);
        return w + 1;
    endfunction

    function automatic int unsigned rem_w(input int unsigned w);
        return w + 2;
    endfunction

endpackage

// File: rtl/isqrt_step.sv
// One restoring square-root digit step: brings down two radicand bits and decides one root bit.
module isqrt_step #(
    parameter int unsigned W = 8
) (
    input  logic [W+2:0] partial_rem,
    input  logic [W:0]   partial_root,
    input  logic [1:0]   next_bits,
    output logic [W+2:0] next_rem,
    output logic         root_bit
);

    logic [W+2:0] shifted;
    logic [W+2:0] sub;
    logic [W+3:0] diff;

    // Extra top bit on the subtraction keeps the borrow visible without truncation.
    always_comb begin
        shifted  = (W+3)'({partial_rem, next_bits});
        sub      = {partial_root, 2'b01};
        diff     = {1'b0, shifted} - {1'b0, sub};
        root_bit = ~diff[W+3];
        next_rem = diff[W+3] ? shifted : diff[W+2:0];
    end

endmodule

// File: rtl/isqrt_unit.sv
// Iterative integer square root: one root bit per cycle, valid/ready on both sides.
module isqrt_unit
    import isqrt_pkg::*;
#(
    parameter int unsigned W = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [rad_w(W)-1:0]    radicand,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [root_w(W)-1:0]   root,
    output logic [rem_w(W)-1:0]    rem,
    output logic                   exact
);

    localparam int unsigned RAD_W  = rad_w(W);
    localparam int unsigned ROOT_W = root_w(W);
    localparam int unsigned REM_W  = rem_w(W);
    localparam int unsigned CNT_W  = (W < 1) ? 1 : $clog2(W + 1);

    state_t             state;
    state_t             state_n;
    logic [RAD_W-1:0]   rad_sr;
    logic [W+2:0]       prem;
    logic [ROOT_W-1:0]  proot;
    logic [CNT_W-1:0]   cnt;

    logic [W+2:0]       step_rem;
    logic               step_bit;
    logic [ROOT_W-1:0]  next_root;

    isqrt_step #(.W(W)) u_step (
        .partial_rem  (prem),
        .partial_root (proot),
        .next_bits    (rad_sr[RAD_W-1 -: 2]),
        .next_rem     (step_rem),
        .root_bit     (step_bit)
    );

    assign next_root = {proot[W-1:0], step_bit};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (in_valid)          state_n = CALC;
            CALC:    if (cnt == '0)         state_n = DONE;
            DONE:    if (out_ready)         state_n = IDLE;
            default:                        state_n = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rad_sr <= '0;
            prem   <= '0;
            proot  <= '0;
            cnt    <= '0;
            root   <= '0;
            rem    <= '0;
            exact  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        rad_sr <= radicand;
                        prem   <= '0;
                        proot  <= '0;
                        cnt    <= CNT_W'(W);
                    end
                end
                CALC: begin
                    rad_sr <= rad_sr << 2;
                    prem   <= step_rem;
                    proot  <= next_root;
                    if (cnt == '0) begin
                        root  <= next_root;
                        rem   <= step_rem[REM_W-1:0];
                        exact <= (step_rem == '0);
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_isqrt_unit.sv
// Directed and randomised checks of isqrt_unit at W=8 against hand values and a reference root.
module tb_isqrt_unit;

    localparam int unsigned W = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [17:0] radicand;
    logic        out_valid;
    logic        out_ready;
    logic [8:0]  root;
    logic [9:0]  rem;
    logic        exact;

    int total = 0;
    int bad   = 0;

    isqrt_unit #(.W(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .radicand  (radicand),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .root      (root),
        .rem       (rem),
        .exact     (exact)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int unsigned ref_sqrt(input int unsigned x);
        int unsigned r = 0;
        while ((r + 1) * (r + 1) <= x) r++;
        return r;
    endfunction

    // Called at a negedge with the unit idle; returns at the negedge after the accept edge.
    task automatic offer(input logic [17:0] r);
        chk("idle_ready", {31'd0, in_ready}, 32'd1);
        in_valid = 1'b1;
        radicand = r;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_out(output int n);
        n = 0;
        while (!out_valid && n < 40) begin
            @(posedge clk);
            n++;
            @(negedge clk);
        end
        chk("out_valid_seen", {31'd0, out_valid}, 32'd1);
    endtask

    task automatic take();
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        chk("take_in_ready", {31'd0, in_ready}, 32'd1);
        chk("take_out_valid", {31'd0, out_valid}, 32'd0);
    endtask

    task automatic directed(input logic [17:0] r, input int er, input int erem, input logic eex);
        int n;
        offer(r);
        wait_out(n);
        chk("latency", n, 32'd9);
        chk("root", root, er);
        chk("rem", rem, erem);
        chk("exact", {31'd0, exact}, {31'd0, eex});
        take();
    endtask

    initial begin
        int n;
        int seen;
        int unsigned r;
        int unsigned er;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        radicand  = '0;
        #12;
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_root", root, 32'd0);
        chk("rst_rem", rem, 32'd0);
        chk("rst_exact", {31'd0, exact}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        directed(18'd0,      0,   0,    1'b1);
        directed(18'd49,     7,   0,    1'b1);
        directed(18'd289,    17,  0,    1'b1);
        directed(18'd290,    17,  1,    1'b0);
        directed(18'd262143, 511, 1022, 1'b0);

        // Backpressure: result must hold while the consumer stalls.
        offer(18'd1000);
        wait_out(n);
        for (int i = 0; i < 5; i++) begin
            in_valid = ~in_valid;
            radicand = 18'($urandom);
            @(posedge clk);
            @(negedge clk);
            chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
            chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
            chk("bp_root", root, 32'd31);
            chk("bp_rem", rem, 32'd39);
        end
        in_valid = 1'b0;
        take();
        chk("bp_root_kept", root, 32'd31);
        chk("bp_rem_kept", rem, 32'd39);

        // Reset during CALC.
        offer(18'd50000);
        repeat (3) begin
            @(posedge clk);
            @(negedge clk);
        end
        #1 rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("mid_rst_root", root, 32'd0);
        chk("mid_rst_rem", rem, 32'd0);
        chk("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (12) begin
            @(posedge clk);
            @(negedge clk);
            if (out_valid) seen++;
        end
        chk("mid_rst_no_result", seen, 32'd0);
        directed(18'd100, 10, 0, 1'b1);

        // Random radicands with idle gaps and consumer stalls.
        for (int k = 0; k < 200; k++) begin
            r  = $urandom_range(0, 262143);
            er = ref_sqrt(r);
            repeat ($urandom_range(0, 2)) @(negedge clk);
            offer(18'(r));
            wait_out(n);
            chk("rnd_latency", n, 32'd9);
            repeat ($urandom_range(0, 3)) begin
                in_valid = 1'($urandom);
                @(posedge clk);
                @(negedge clk);
            end
            in_valid = 1'b0;
            chk("rnd_root", root, er);
            chk("rnd_rem", rem, r - er * er);
            chk("rnd_sum", 32'(root) * 32'(root) + 32'(rem), r);
            chk("rnd_bound", {31'd0, (32'(rem) <= 2 * 32'(root))}, 32'd1);
            chk("rnd_exact", {31'd0, exact}, {31'd0, (r == er * er)});
            take();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
